aes128_encrypt: RTL and testbench

- Fully pipelined AES-128 encryption datapath (FIPS-197) that accepts one 128-bit plaintext block per enabled clock and emits the ciphertext after 11 enabled clocks.
- Key expansion is external: the 11 round keys are supplied pre-expanded on a port array.
- Sits behind a block source and in front of a consumer; `en` is a global pipeline advance/stall control.

---
 rtl/aes128_encrypt.sv | 145 ++++++++++++++
 tb/tb_aes128_encrypt.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt.sv
// aes128_encrypt: fully pipelined AES-128 encryption datapath (FIPS-197).
// The caller supplies the round keys already expanded. The pipeline has eleven
// register stages and advances only on edges where en=1.
// Build option AES_SBOX_GF_EN: when defined, the S-box is computed from the
// GF(2^8) inverse and the affine transform. When undefined, it is a lookup table.
module aes128_encrypt #(
  parameter int unsigned NR = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           valid_i,
  input  logic [127:0]   plaintext_i,
  input  logic [127:0]   round_key_i [NR:0],
  output logic           valid_o,
  output logic [127:0]   ciphertext_o
);

  localparam int unsigned W  = 128;
  localparam int unsigned BW = 8;
  localparam int unsigned NB = W / BW;

  function automatic logic [BW-1:0] xtime(input logic [BW-1:0] b);
    xtime = {b[6:0], 1'b0} ^ (8'h1B & {BW{b[7]}});
  endfunction

`ifdef AES_SBOX_GF_EN
  function automatic logic [BW-1:0] gf_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] p;
    logic [BW-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // x^254 gives the multiplicative inverse, and 0 maps to 0.
  // 254 = 2+4+...+128, so the inverse is the product of the squarings.
  function automatic logic [BW-1:0] sbox(input logic [BW-1:0] x);
    logic [BW-1:0] p;
    logic [BW-1:0] inv;
    logic [BW-1:0] o;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    for (int i = 0; i < 8; i++) begin
      o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
             inv[(i + 7) % 8];
    end
    sbox = o ^ 8'h63;
  endfunction
`else
  localparam logic [BW-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [BW-1:0] sbox(input logic [BW-1:0] x);
    sbox = SBOX[x];
  endfunction
`endif

  function automatic logic [W-1:0] sub_bytes(input logic [W-1:0] s);
    logic [W-1:0] o;
    for (int k = 0; k < NB; k++) o[W-1-8*k -: 8] = sbox(s[W-1-8*k -: 8]);
    sub_bytes = o;
  endfunction

  // Byte k sits at row k%4 and column k/4. Row r rotates left by r columns.
  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s);
    logic [W-1:0] o;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        o[W-1-8*(row+4*col) -: 8] = s[W-1-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    shift_rows = o;
  endfunction

  function automatic logic [W-1:0] mix_columns(input logic [W-1:0] s);
    logic [W-1:0]  o;
    logic [BW-1:0] a0, a1, a2, a3;
    for (int col = 0; col < 4; col++) begin
      a0 = s[W-1-32*col -: 8];
      a1 = s[W-9-32*col -: 8];
      a2 = s[W-17-32*col -: 8];
      a3 = s[W-25-32*col -: 8];
      o[W-1-32*col  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[W-9-32*col  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[W-17-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[W-25-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    mix_columns = o;
  endfunction

  logic [W-1:0] st  [NR+1];
  logic [W-1:0] nxt [NR+1];
  logic [NR:0]  vld;

  // Next value of each stage: the initial key add, the full rounds, and the final round without MixColumns.
  always_comb begin
    nxt[0] = plaintext_i ^ round_key_i[0];
    for (int r = 1; r < int'(NR); r++) begin
      nxt[r] = mix_columns(shift_rows(sub_bytes(st[r-1]))) ^ round_key_i[r];
    end
    nxt[NR] = shift_rows(sub_bytes(st[NR-1])) ^ round_key_i[NR];
  end

  // Stage registers. A stall freezes every stage and drops the output valid, so no pulse repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r <= int'(NR); r++) st[r] <= '0;
      vld <= '0;
    end else if (en) begin
      for (int r = 0; r <= int'(NR); r++) st[r] <= nxt[r];
      vld <= {vld[NR-1:0], valid_i};
    end else begin
      vld[NR] <= 1'b0;
    end
  end

  assign ciphertext_o = st[NR];
  assign valid_o      = vld[NR];

endmodule

// File: tb/tb_aes128_encrypt.sv
// Self-checking bench for aes128_encrypt. A reference model computes the S-box
// by brute-force inverse search and expands the key. Expected ciphertexts are
// queued when a block is accepted and compared when valid_o appears.
module tb_aes128_encrypt;

  logic         clk;
  logic         rst;
  logic         en;
  logic         valid_i;
  logic [127:0] plaintext_i;
  logic [127:0] rk [10:0];
  logic         valid_o;
  logic [127:0] ciphertext_o;

  logic [7:0]   tb_sbox [256];
  logic [127:0] exp_q [$];
  int           checks;
  int           errors;

  aes128_encrypt #(.NR(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .valid_i      (valid_i),
    .plaintext_i  (plaintext_i),
    .round_key_i  (rk),
    .valid_o      (valid_o),
    .ciphertext_o (ciphertext_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = (b << 1) ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    rotl = (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      tb_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] x;
    x = pt ^ rk[0];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) s[k] = tb_sbox[x[127-8*k -: 8]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row+4*col] = s[row+4*((col+row)%4)];
      if (rnd < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
          t[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          t[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          t[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          t[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) x[127-8*k -: 8] = t[k];
      x = x ^ rk[rnd];
    end
    ref_enc = x;
  endfunction

  function automatic logic [127:0] rand128();
    rand128 = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one slot at the falling edge; accepted blocks enter the scoreboard.
  task automatic drive(input logic e, input logic v, input logic [127:0] pt);
    @(negedge clk);
    en          = e;
    valid_i     = v;
    plaintext_i = pt;
    if (e && v) exp_q.push_back(ref_enc(pt));
  endtask

  // Run enabled bubbles until valid_o rises; lat counts falling edges waited.
  task automatic idle_until_valid(input string tag, output int lat);
    logic seen;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      seen        = valid_o;
      en          = 1'b1;
      valid_i     = 1'b0;
      plaintext_i = rand128();
    end
    if (!seen) check({tag, "_timeout"}, 128'(seen), 128'(1));
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding block.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (exp_q.size() == 0) check("extra_pulse", 128'(valid_o), 128'(0));
      else check("ciphertext", ciphertext_o, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int sent;
    logic b;
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    en          = 1'b0;
    valid_i     = 1'b0;
    plaintext_i = '0;
    for (int r = 0; r < 11; r++) rk[r] = '0;
    build_sbox();

    #1 rst = 1'b1;
    #2;
    check("reset_valid", 128'(valid_o), 128'(0));
    check("reset_ct", ciphertext_o, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // FIPS-197 C.1 with bench-expanded key; also verifies 11-cycle latency.
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    check("c1_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    drive(1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff);
    idle_until_valid("c1", lat);
    check("c1_latency", 128'(lat), 128'(11));
    check("c1_ct", ciphertext_o, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge clk);
    check("c1_single_pulse", 128'(valid_o), 128'(0));

    // FIPS-197 Appendix B.
    expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    drive(1'b1, 1'b1, 128'h3243f6a8885a308d313198a2e0370734);
    idle_until_valid("appb", lat);
    check("appb_latency", 128'(lat), 128'(11));
    check("appb_ct", ciphertext_o, 128'h3925841d02dc09fbdc118597196a0b32);

    // Back-to-back: five consecutive blocks give five consecutive pulses.
    expand_key(rand128());
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, rand128());
    idle_until_valid("b2b", lat);
    check("b2b_first_lat", 128'(lat), 128'(7));
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("b2b_run", 128'(valid_o), 128'(1));
    end
    @(negedge clk);
    check("b2b_end", 128'(valid_o), 128'(0));
    check("b2b_drained", 128'(exp_q.size()), 128'(0));

    // Random stalls: en and valid_i move together.
    sent = 0;
    while (sent < 5) begin
      b = 1'($urandom_range(0, 1));
      drive(b, b, rand128());
      if (b) sent++;
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      b = 1'($urandom_range(0, 1));
      drive(b, 1'b0, rand128());
    end
    check("stall_drained", 128'(exp_q.size()), 128'(0));
    repeat (4) drive(1'b0, 1'b1, rand128());
    check("stall_ignored", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset while three blocks are in flight.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, rand128());
    drive(1'b1, 1'b0, rand128());
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 128'(valid_o), 128'(0));
    check("midrst_ct", ciphertext_o, 128'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, rand128());
    drive(1'b1, 1'b1, rand128());
    idle_until_valid("postrst", lat);
    check("postrst_latency", 128'(lat), 128'(11));
    repeat (3) drive(1'b1, 1'b0, rand128());
    check("final_drained", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
